// File: rtl/neuron_accumulator_if.sv
// Bundle of the weight-event, update-control, threshold_unit and spike-event signals
// seen by neuron_accumulator; slave is the accumulator side, master the environment.
interface neuron_accumulator_if #(
    parameter int unsigned size_data   = 8,
    parameter int unsigned size_vmem   = 16,
    parameter int unsigned NUM_NEURONS = 16
);
    localparam int unsigned ADDR_W = $clog2(NUM_NEURONS);

    logic                 in_valid;
    logic                 in_ready;
    logic [ADDR_W-1:0]    in_addr;
    logic [size_data-1:0] in_weight;
    logic                 upd_start;
    logic                 upd_busy;
    logic                 upd_done;
    logic                 tu_update;
    logic [size_vmem-1:0] tu_impulse;
    logic                 tu_spike;
    logic [size_vmem-1:0] tu_vmem;
    logic                 spk_valid;
    logic                 spk_ready;
    logic [ADDR_W-1:0]    spk_addr;

    modport slave (
        input  in_valid, in_addr, in_weight, upd_start, tu_spike, tu_vmem, spk_ready,
        output in_ready, upd_busy, upd_done, tu_update, tu_impulse, spk_valid, spk_addr
    );

    modport master (
        output in_valid, in_addr, in_weight, upd_start, tu_spike, tu_vmem, spk_ready,
        input  in_ready, upd_busy, upd_done, tu_update, tu_impulse, spk_valid, spk_addr
    );
endinterface

// File: rtl/neuron_accumulator.sv
// Per-neuron membrane potential store: saturating weight integration while idle, and an
// update sweep that feeds leaked potentials to threshold_unit and emits spike events.
module neuron_accumulator #(
    parameter int unsigned size_data   = 8,
    parameter int unsigned size_vmem   = 16,
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned LEAK_SHIFT  = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    neuron_accumulator_if.slave  bus
);
    localparam int unsigned ADDR_W = $clog2(NUM_NEURONS);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_NEURONS - 1);
    localparam logic signed [size_vmem-1:0] VmemMax = {1'b0, {(size_vmem-1){1'b1}}};
    localparam logic signed [size_vmem-1:0] VmemMin = {1'b1, {(size_vmem-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StSweep, StSpk, StDone} state_e;

    state_e                      state_q;
    logic [ADDR_W-1:0]           idx_q;
    logic                        spk_valid_q;
    logic [ADDR_W-1:0]           spk_addr_q;
    logic signed [size_vmem-1:0] vmem_q [NUM_NEURONS];

    logic                        addr_ok;
    logic signed [size_vmem:0]   sum;
    logic signed [size_vmem-1:0] sat_sum;
    logic signed [size_vmem-1:0] cur_vmem;
    logic signed [size_vmem-1:0] leaked;

    always_comb begin
        addr_ok = 32'(bus.in_addr) < NUM_NEURONS;
        // One guard bit: overflow shows up as the two top bits disagreeing.
        sum = {vmem_q[bus.in_addr][size_vmem-1], vmem_q[bus.in_addr]}
            + {{(size_vmem+1-size_data){bus.in_weight[size_data-1]}}, bus.in_weight};
        if (sum[size_vmem] != sum[size_vmem-1]) begin
            sat_sum = sum[size_vmem] ? VmemMin : VmemMax;
        end else begin
            sat_sum = sum[size_vmem-1:0];
        end
        cur_vmem = vmem_q[idx_q];
        // A zero shift would otherwise leak the whole potential away.
        leaked = (LEAK_SHIFT == 0) ? cur_vmem : cur_vmem - (cur_vmem >>> LEAK_SHIFT);
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.upd_busy   = (state_q != StIdle);
    assign bus.upd_done   = (state_q == StDone);
    assign bus.tu_update  = (state_q == StSweep);
    assign bus.tu_impulse = (state_q == StSweep) ? leaked : '0;
    assign bus.spk_valid  = spk_valid_q;
    assign bus.spk_addr   = spk_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            spk_valid_q <= 1'b0;
            spk_addr_q  <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                vmem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    // Accept lands on the same edge as the start, so the sweep sees it.
                    if (bus.in_valid && addr_ok) begin
                        vmem_q[bus.in_addr] <= sat_sum;
                    end
                    if (bus.upd_start) begin
                        state_q <= StSweep;
                        idx_q   <= '0;
                    end
                end
                StSweep: begin
                    vmem_q[idx_q] <= bus.tu_vmem;
                    if (bus.tu_spike) begin
                        spk_valid_q <= 1'b1;
                        spk_addr_q  <= idx_q;
                        state_q     <= StSpk;
                    end else if (idx_q == LastIdx) begin
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StSpk: begin
                    if (bus.spk_ready) begin
                        spk_valid_q <= 1'b0;
                        if (idx_q == LastIdx) begin
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= StSweep;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    idx_q   <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator; a behavioural threshold_unit fires at impulse >= 256
// and returns vmem 0 on a spike, else the impulse unchanged.
module tb_neuron_accumulator;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    neuron_accumulator_if #(.size_data(8), .size_vmem(16), .NUM_NEURONS(16)) nif ();
    neuron_accumulator_if #(.size_data(8), .size_vmem(16), .NUM_NEURONS(16)) nif2 ();

    neuron_accumulator #(.size_data(8), .size_vmem(16), .NUM_NEURONS(16), .LEAK_SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(nif)
    );
    neuron_accumulator #(.size_data(8), .size_vmem(16), .NUM_NEURONS(16), .LEAK_SHIFT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(nif2)
    );

    assign nif.tu_spike  = $signed(nif.tu_impulse) >= 16'sd256;
    assign nif.tu_vmem   = nif.tu_spike ? '0 : nif.tu_impulse;
    assign nif2.tu_spike = $signed(nif2.tu_impulse) >= 16'sd256;
    assign nif2.tu_vmem  = nif2.tu_spike ? '0 : nif2.tu_impulse;

    always #5 clk = ~clk;

    logic [15:0] obs_imp [16];
    logic [3:0]  spk_q [$];
    int          done_cnt, done_at, pos;
    bit          hold_ok, paused_ok, busy_ok, ready_ok, timeout;
    logic [15:0] imp2 [16];
    logic [3:0]  spk2_q [$];
    int          done2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        nif.in_valid = 0; nif.in_addr = 0; nif.in_weight = 0; nif.upd_start = 0;
        nif.spk_ready = 1;
        nif2.in_valid = 0; nif2.in_addr = 0; nif2.in_weight = 0; nif2.upd_start = 0;
        nif2.spk_ready = 1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_n(input logic [3:0] a, input logic [7:0] w, input int n);
        nif.in_valid = 1; nif.in_addr = a; nif.in_weight = w;
        repeat (n) tick();
        nif.in_valid = 0;
    endtask

    task automatic send2_n(input logic [3:0] a, input logic [7:0] w, input int n);
        nif2.in_valid = 1; nif2.in_addr = a; nif2.in_weight = w;
        repeat (n) tick();
        nif2.in_valid = 0;
    endtask

    // Starts a sweep on nif and records impulses, spikes, done pulses and protocol flags.
    task automatic run_sweep(input int stall, input bit wr, input logic [3:0] wa,
                             input logic [7:0] ww, input bit hold_valid);
        int k, stall_left;
        bit pend;
        logic [3:0] pend_addr;
        stall_left = stall; pos = 0; done_cnt = 0; done_at = -1; spk_q.delete();
        hold_ok = 1; paused_ok = 1; busy_ok = 1; ready_ok = 1; timeout = 0; pend = 0;
        pend_addr = 0;
        for (int i = 0; i < 16; i++) obs_imp[i] = 'x;
        nif.upd_start = 1; nif.in_valid = wr; nif.in_addr = wa; nif.in_weight = ww;
        tick();
        nif.upd_start = 0; nif.in_valid = hold_valid; nif.in_addr = 4'd6; nif.in_weight = 8'd127;
        k = 0;
        while (done_cnt == 0 && k < 300) begin
            if (!nif.upd_busy) busy_ok = 0;
            if (nif.in_ready) ready_ok = 0;
            if (pend && (!nif.spk_valid || nif.spk_addr !== pend_addr)) hold_ok = 0;
            pend = 0;
            if (nif.tu_update) begin
                if (pos < 16) obs_imp[pos] = nif.tu_impulse;
                pos++;
            end
            if (nif.spk_valid) begin
                if (nif.tu_update) paused_ok = 0;
                if (stall_left > 0) begin
                    nif.spk_ready = 0; stall_left--; pend = 1; pend_addr = nif.spk_addr;
                end else begin
                    nif.spk_ready = 1; spk_q.push_back(nif.spk_addr);
                end
            end else begin
                nif.spk_ready = 1;
            end
            if (nif.upd_done) begin
                done_cnt++; done_at = k; nif.in_valid = 0;
            end
            tick();
            k++;
        end
        if (done_cnt == 0) timeout = 1;
        nif.in_valid = 0; nif.spk_ready = 1;
        repeat (3) begin
            if (nif.upd_done) done_cnt++;
            tick();
        end
    endtask

    task automatic leak_sweep();
        int k, p;
        spk2_q.delete(); done2 = 0; p = 0;
        for (int i = 0; i < 16; i++) imp2[i] = 'x;
        nif2.upd_start = 1;
        tick();
        nif2.upd_start = 0;
        k = 0;
        while (done2 == 0 && k < 100) begin
            if (nif2.tu_update) begin
                if (p < 16) imp2[p] = nif2.tu_impulse;
                p++;
            end
            if (nif2.spk_valid) spk2_q.push_back(nif2.spk_addr);
            if (nif2.upd_done) done2++;
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 0;
        nif.in_valid = 0; nif.in_addr = 0; nif.in_weight = 0; nif.upd_start = 0;
        nif.spk_ready = 1;
        nif2.in_valid = 0; nif2.in_addr = 0; nif2.in_weight = 0; nif2.upd_start = 0;
        nif2.spk_ready = 1;
        tick(); tick();
        checks++; if (nif.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", nif.in_ready); end
        checks++; if (nif.upd_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", nif.upd_busy); end
        checks++; if (nif.upd_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", nif.upd_done); end
        checks++; if (nif.tu_update !== 1'b0) begin errors++; $display("FAIL rst_tu_update got %b want 0", nif.tu_update); end
        checks++; if (nif.spk_valid !== 1'b0) begin errors++; $display("FAIL rst_spk_valid got %b want 0", nif.spk_valid); end
        checks++; if (nif.spk_addr !== 4'd0) begin errors++; $display("FAIL rst_spk_addr got %0d want 0", nif.spk_addr); end
        checks++; if (nif.tu_impulse !== 16'd0) begin errors++; $display("FAIL rst_impulse got %h want 0000", nif.tu_impulse); end
        rst_n = 1;
        tick();
        nif.in_valid = 1; nif.in_addr = 4'd2; nif.in_weight = 8'd50;
        tick(); tick();
        rst_n = 0;
        #1;
        checks++; if (nif.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", nif.in_ready); end
        checks++; if (nif.tu_impulse !== 16'd0) begin errors++; $display("FAIL midrst_impulse got %h want 0000", nif.tu_impulse); end
        nif.in_valid = 0;
        tick();
        rst_n = 1;
        tick();
        run_sweep(0, 0, 4'd0, 8'd0, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (obs_imp[i] !== 16'd0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_sweep_zero got %0d nonzero want 0", bad); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rst_sweep_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_integrate_spike();
        apply_reset();
        send_n(4'd3, 8'd100, 3);
        run_sweep(0, 0, 4'd0, 8'd0, 0);
        checks++; if (obs_imp[3] !== 16'd300) begin errors++; $display("FAIL int_imp3 got %h want 012c", obs_imp[3]); end
        checks++; if (obs_imp[2] !== 16'd0) begin errors++; $display("FAIL int_imp2 got %h want 0000", obs_imp[2]); end
        checks++; if (spk_q.size() != 1) begin errors++; $display("FAIL int_spk_cnt got %0d want 1", spk_q.size()); end
        if (spk_q.size() > 0) begin
            checks++; if (spk_q[0] !== 4'd3) begin errors++; $display("FAIL int_spk_addr got %0d want 3", spk_q[0]); end
        end
        checks++; if (done_at != 17) begin errors++; $display("FAIL int_latency got %0d want 17", done_at); end
        checks++; if (timeout) begin errors++; $display("FAIL int_timeout got 1 want 0"); end
        run_sweep(0, 0, 4'd0, 8'd0, 0);
        checks++; if (obs_imp[3] !== 16'd0) begin errors++; $display("FAIL int_imp3_after got %h want 0000", obs_imp[3]); end
        checks++; if (done_at != 16) begin errors++; $display("FAIL nospk_latency got %0d want 16", done_at); end
        checks++; if (!busy_ok) begin errors++; $display("FAIL busy_during_sweep got 0 want 1"); end
        checks++; if (pos != 16) begin errors++; $display("FAIL sweep_cycles got %0d want 16", pos); end
    endtask

    task automatic test_saturation();
        apply_reset();
        send_n(4'd0, 8'd127, 300);
        send_n(4'd1, 8'h80, 300);
        run_sweep(0, 0, 4'd0, 8'd0, 0);
        checks++; if (obs_imp[0] !== 16'h7fff) begin errors++; $display("FAIL sat_pos got %h want 7fff", obs_imp[0]); end
        checks++; if (obs_imp[1] !== 16'h8000) begin errors++; $display("FAIL sat_neg got %h want 8000", obs_imp[1]); end
        checks++; if (spk_q.size() != 1) begin errors++; $display("FAIL sat_spk_cnt got %0d want 1", spk_q.size()); end
        if (spk_q.size() > 0) begin
            checks++; if (spk_q[0] !== 4'd0) begin errors++; $display("FAIL sat_spk_addr got %0d want 0", spk_q[0]); end
        end
        run_sweep(0, 0, 4'd0, 8'd0, 0);
        checks++; if (obs_imp[1] !== 16'h8000) begin errors++; $display("FAIL sat_neg_kept got %h want 8000", obs_imp[1]); end
        checks++; if (obs_imp[0] !== 16'd0) begin errors++; $display("FAIL sat_pos_cleared got %h want 0000", obs_imp[0]); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        send_n(4'd1, 8'd127, 2);
        send_n(4'd1, 8'd10, 1);
        send_n(4'd2, 8'd127, 3);
        run_sweep(5, 0, 4'd0, 8'd0, 0);
        checks++; if (obs_imp[1] !== 16'd264) begin errors++; $display("FAIL bp_imp1 got %h want 0108", obs_imp[1]); end
        checks++; if (obs_imp[2] !== 16'd381) begin errors++; $display("FAIL bp_imp2 got %h want 017d", obs_imp[2]); end
        checks++; if (spk_q.size() != 2) begin errors++; $display("FAIL bp_spk_cnt got %0d want 2", spk_q.size()); end
        if (spk_q.size() == 2) begin
            checks++; if (spk_q[0] !== 4'd1 || spk_q[1] !== 4'd2) begin
                errors++; $display("FAIL bp_spk_order got %0d,%0d want 1,2", spk_q[0], spk_q[1]);
            end
        end
        checks++; if (!hold_ok) begin errors++; $display("FAIL bp_hold got 0 want 1"); end
        checks++; if (!paused_ok) begin errors++; $display("FAIL bp_paused got 0 want 1"); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt got %0d want 1", done_cnt); end
        checks++; if (done_at != 23) begin errors++; $display("FAIL bp_latency got %0d want 23", done_at); end
    endtask

    task automatic test_leak();
        apply_reset();
        send2_n(4'd0, 8'd127, 3);
        send2_n(4'd0, 8'd19, 1);
        send2_n(4'd4, 8'd127, 4);
        send2_n(4'd4, 8'd92, 1);
        leak_sweep();
        checks++; if (imp2[0] !== 16'd200) begin errors++; $display("FAIL leak_imp0 got %h want 00c8", imp2[0]); end
        checks++; if (imp2[4] !== 16'd300) begin errors++; $display("FAIL leak_imp4 got %h want 012c", imp2[4]); end
        checks++; if (spk2_q.size() != 1) begin errors++; $display("FAIL leak_spk_cnt got %0d want 1", spk2_q.size()); end
        if (spk2_q.size() > 0) begin
            checks++; if (spk2_q[0] !== 4'd4) begin errors++; $display("FAIL leak_spk_addr got %0d want 4", spk2_q[0]); end
        end
        checks++; if (done2 != 1) begin errors++; $display("FAIL leak_done got %0d want 1", done2); end
        tick();
        leak_sweep();
        checks++; if (imp2[0] !== 16'd100) begin errors++; $display("FAIL leak_imp0_2 got %h want 0064", imp2[0]); end
        checks++; if (imp2[4] !== 16'd0) begin errors++; $display("FAIL leak_imp4_2 got %h want 0000", imp2[4]); end
    endtask

    task automatic test_same_cycle();
        int nd;
        apply_reset();
        send_n(4'd5, 8'd127, 1);
        send_n(4'd5, 8'd11, 1);
        run_sweep(0, 1, 4'd5, 8'd127, 1);
        checks++; if (obs_imp[5] !== 16'd265) begin errors++; $display("FAIL same_imp5 got %h want 0109", obs_imp[5]); end
        checks++; if (spk_q.size() != 1) begin errors++; $display("FAIL same_spk_cnt got %0d want 1", spk_q.size()); end
        if (spk_q.size() > 0) begin
            checks++; if (spk_q[0] !== 4'd5) begin errors++; $display("FAIL same_spk_addr got %0d want 5", spk_q[0]); end
        end
        checks++; if (!ready_ok) begin errors++; $display("FAIL sweep_in_ready got 1 want 0"); end
        run_sweep(0, 0, 4'd0, 8'd0, 0);
        checks++; if (obs_imp[6] !== 16'd0) begin errors++; $display("FAIL sweep_write_ignored got %h want 0000", obs_imp[6]); end
        nif.upd_start = 1;
        tick();
        nif.upd_start = 0;
        repeat (4) tick();
        rst_n = 0;
        #1;
        checks++; if (nif.upd_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", nif.upd_busy); end
        checks++; if (nif.tu_update !== 1'b0) begin errors++; $display("FAIL abort_tu_update got %b want 0", nif.tu_update); end
        tick();
        rst_n = 1;
        nd = 0;
        repeat (25) begin
            if (nif.upd_done) nd++;
            tick();
        end
        checks++; if (nd != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", nd); end
    endtask

    initial begin
        clk = 0;
        checks = 0;
        errors = 0;
        test_reset();
        test_integrate_spike();
        test_saturation();
        test_back_to_back();
        test_leak();
        test_same_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
